// File: rtl/alu_op_sequencer.sv
// Command-issue stage for the 32-bit ALU: buffers requests in a FIFO, issues them
// one at a time, chains through an accumulator and returns results over valid/ready.
module alu_op_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic        cmd_use_acc,
  input  logic        cmd_wr_acc,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_error,
  output logic [31:0] acc,
  output logic        busy
);

  localparam logic [3:0] OP_NOOP  = 4'b0000;
  localparam logic [3:0] OP_RESET = 4'b0001;
  localparam logic [3:0] OP_OR    = 4'b0010;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_ADD   = 4'b0110;
  localparam logic [3:0] OP_NOT   = 4'b0111;
  localparam logic [3:0] OP_SUB   = 4'b1000;
  localparam logic [3:0] OP_EQUAL = 4'b1100;
  localparam logic [3:0] OP_GT    = 4'b1101;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
  typedef enum logic [1:0] {C_ALU, C_NOOP, C_RESET, C_ILL} cls_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        use_acc;
    logic        wr_acc;
  } cmd_t;

  function automatic cls_t classify(input logic [3:0] op);
    case (op)
      OP_OR, OP_AND, OP_ADD, OP_NOT, OP_SUB, OP_EQUAL, OP_GT: classify = C_ALU;
      OP_NOOP:  classify = C_NOOP;
      OP_RESET: classify = C_RESET;
      default:  classify = C_ILL;
    endcase
  endfunction

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  cmd_t          head;
  cls_t          head_cls;

  state_t        state_q;
  state_t        state_d;
  cls_t          cls_q;
  logic          wr_acc_q;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign head      = mem[rd_ptr];
  assign head_cls  = classify(head.op);
  assign rsp_valid = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{op: cmd_op, a: cmd_a, b: cmd_b,
                       use_acc: cmd_use_acc, wr_acc: cmd_wr_acc};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // acc is only written in EXEC, so the value read at pop already reflects all earlier commands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= OP_NOOP;
      cls_q      <= C_NOOP;
      wr_acc_q   <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_error  <= 1'b0;
      acc        <= '0;
    end else begin
      if (pop) begin
        alu_a    <= head.use_acc ? acc : head.a;
        alu_b    <= head.b;
        alu_op   <= (head_cls == C_ALU) ? head.op : OP_NOOP;
        cls_q    <= head_cls;
        wr_acc_q <= head.wr_acc;
      end
      if (state_q == S_EXEC) begin
        case (cls_q)
          C_ALU: begin
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
            rsp_error  <= 1'b0;
            if (wr_acc_q) acc <= alu_result;
          end
          C_NOOP: begin
            rsp_result <= acc;
            rsp_zero   <= (acc == '0);
            rsp_error  <= 1'b0;
          end
          C_RESET: begin
            acc        <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b1;
            rsp_error  <= 1'b0;
          end
          default: begin
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_error  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU + in-order response model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [31:0] cmd_a = '0;
  logic [31:0] cmd_b = '0;
  logic        cmd_use_acc = 1'b0;
  logic        cmd_wr_acc = 1'b0;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_error;
  logic [31:0] acc;
  logic        busy;

  alu_op_sequencer #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .cmd_wr_acc(cmd_wr_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_error(rsp_error), .acc(acc), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0010: alu_fn = a | b;
      4'b0101: alu_fn = a & b;
      4'b0110: alu_fn = a + b;
      4'b0111: alu_fn = ~a;
      4'b1000: alu_fn = a - b;
      4'b1100: alu_fn = {31'b0, a == b};
      4'b1101: alu_fn = {31'b0, a > b};
      default: alu_fn = '0;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_fn(alu_op, alu_a, alu_b);
    alu_zero   = (alu_result == '0);
  end

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic        error;
    logic [31:0] acc_after;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] macc = '0;
  int unsigned tests = 0;
  int unsigned errors = 0;
  int unsigned rsp_count = 0;
  int unsigned rr_mode = 0;
  logic [31:0] last_result = '0;
  logic        last_zero = 1'b0;
  logic        last_error = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_push();
    exp_t e;
    logic [31:0] opa;
    opa = cmd_use_acc ? macc : cmd_a;
    case (cmd_op)
      4'b0010, 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1100, 4'b1101: begin
        e.result = alu_fn(cmd_op, opa, cmd_b);
        e.zero   = (e.result == 0);
        e.error  = 1'b0;
        if (cmd_wr_acc) macc = e.result;
      end
      4'b0000: begin e.result = macc; e.zero = (macc == 0); e.error = 1'b0; end
      4'b0001: begin macc = '0; e.result = '0; e.zero = 1'b1; e.error = 1'b0; end
      default: begin e.result = '0; e.zero = 1'b0; e.error = 1'b1; end
    endcase
    e.acc_after = macc;
    exp_q.push_back(e);
  endtask

  // Per-cycle comparison against the in-order model
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      exp_q.delete();
      macc = '0;
    end else begin
      if (exp_q.size() > 0) chk("busy_inflight", busy, 1);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          tests++; errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 result=%h expected no response", rsp_result);
        end else begin
          chk("rsp_result", rsp_result, exp_q[0].result);
          chk("rsp_zero", rsp_zero, exp_q[0].zero);
          chk("rsp_error", rsp_error, exp_q[0].error);
          if (rsp_ready) begin
            chk("acc_after", acc, exp_q[0].acc_after);
            last_result = rsp_result;
            last_zero   = rsp_zero;
            last_error  = rsp_error;
            rsp_count++;
            void'(exp_q.pop_front());
          end
        end
      end
      if (cmd_valid && cmd_ready) model_push();
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (rr_mode)
      0:       rsp_ready = 1'b0;
      1:       rsp_ready = 1'b1;
      default: rsp_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic ua, input logic wa);
    int unsigned n = 0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_wr_acc = wa;
    cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      tests++; errors++;
      $display("FAIL send_timeout: got cmd_ready=0 expected 1 within 200 cycles");
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    @(negedge clk);
    while ((busy || rsp_valid || exp_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", (n < 300), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] first;
    int unsigned cnt0;
    int unsigned seen;
    #3;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acc", acc, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_error", rsp_error, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rr_mode = 1;
    @(posedge clk);
    #1;

    // Single ADD: latency and one-cycle response
    cmd_op = 4'b0110; cmd_a = 32'd5; cmd_b = 32'd7; cmd_use_acc = 0; cmd_wr_acc = 0;
    cmd_valid = 1'b1;
    @(negedge clk); chk("t1_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk); chk("t1_valid_t0", rsp_valid, 0);
    @(negedge clk); chk("t1_alu_op_exec", alu_op, 4'b0110); chk("t1_valid_t1", rsp_valid, 0);
    @(negedge clk); chk("t1_valid_t2", rsp_valid, 1); chk("t1_result", rsp_result, 12);
    chk("t1_zero", rsp_zero, 0); chk("t1_error", rsp_error, 0);
    @(negedge clk); chk("t1_valid_t3", rsp_valid, 0);
    wait_idle();

    // Accumulator chaining
    send(4'b0110, 32'd10, 32'd0, 0, 1);
    send(4'b1000, 32'd0, 32'd10, 1, 1);
    wait_idle();
    chk("chain_result", last_result, 0);
    chk("chain_zero", last_zero, 1);
    chk("chain_acc", acc, 0);

    // Fill the FIFO with the consumer stalled
    rr_mode = 0;
    cnt0 = rsp_count;
    send(4'b0110, 32'd1, 32'd2, 0, 0);
    send(4'b0110, 32'd3, 32'd4, 0, 0);
    send(4'b1000, 32'd10, 32'd3, 0, 0);
    send(4'b0010, 32'hf0, 32'h0f, 0, 0);
    send(4'b0101, 32'hff, 32'h0f, 0, 0);
    @(negedge clk);
    chk("fill_cmd_ready", cmd_ready, 0);
    chk("fill_valid", rsp_valid, 1);
    first = rsp_result;
    chk("fill_first", first, 3);
    repeat (10) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_result", rsp_result, first);
    end
    rr_mode = 1;
    wait_idle();
    chk("fill_drained", rsp_count - cnt0, 5);
    chk("fill_last", last_result, 32'h0f);

    // Illegal opcodes leave acc alone
    send(4'b0110, 32'h1234, 32'd0, 0, 1);
    send(4'b0011, 32'd9, 32'd9, 0, 1);
    send(4'b1111, 32'd9, 32'd9, 0, 1);
    wait_idle();
    chk("ill_error", last_error, 1);
    chk("ill_result", last_result, 0);
    chk("ill_acc", acc, 32'h1234);
    send(4'b0110, 32'd1, 32'd1, 0, 0);
    wait_idle();
    chk("ill_then_add", last_result, 2);

    // RESET opcode clears acc, NOOP then reports it
    send(4'b0110, 32'hDEADBEEF, 32'd0, 0, 1);
    wait_idle();
    chk("pre_reset_acc", acc, 32'hDEADBEEF);
    send(4'b0001, 32'd5, 32'd5, 0, 1);
    wait_idle();
    chk("rstop_result", last_result, 0);
    chk("rstop_zero", last_zero, 1);
    chk("rstop_acc", acc, 0);
    send(4'b0000, 32'd7, 32'd7, 0, 0);
    wait_idle();
    chk("noop_result", last_result, 0);
    chk("noop_zero", last_zero, 1);

    // Randomized traffic with a random consumer
    rr_mode = 2;
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      send(4'($urandom_range(0, 15)), a, b, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
    rr_mode = 1;
    wait_idle();

    // Asynchronous reset while a response is pending and two commands are queued
    rr_mode = 0;
    send(4'b0110, 32'd3, 32'd4, 0, 1);
    send(4'b0110, 32'd1, 32'd1, 0, 0);
    send(4'b0110, 32'd2, 32'd2, 0, 0);
    seen = 0;
    @(negedge clk);
    while (!rsp_valid && seen < 20) begin
      @(negedge clk);
      seen++;
    end
    chk("ar_resp_reached", rsp_valid, 1);
    chk("ar_acc_before", acc, 7);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_rsp_valid", rsp_valid, 0);
    chk("ar_acc", acc, 0);
    chk("ar_busy", busy, 0);
    chk("ar_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    rr_mode = 1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("ar_no_stale", seen, 0);
    chk("ar_idle_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish before 300000");
    $fatal(1);
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Command-issue stage that sits in front of the 32-bit ALU datapath and buffers incoming operation requests in a small FIFO.
- Drives the ALU operand and opcode lines from registers and captures the ALU result and zero flag one cycle later.
- Keeps a 32-bit accumulator that can chain operations.
- Returns each result through a valid/ready response port.

Parameters:
DEPTH, 4, command FIFO entries; power of two, minimum 2
AW, 2, FIFO pointer width; log2(DEPTH)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept a command
cmd_op  in  4  opcode (team ALU encoding)
cmd_a  in  32  operand A
cmd_b  in  32  operand B
cmd_use_acc  in  1  use accumulator in place of cmd_a
cmd_wr_acc  in  1  write result into accumulator
alu_a  out  32  registered operand A to ALU
alu_b  out  32  registered operand B to ALU
alu_op  out  4  registered opcode to ALU
alu_result  in  32  ALU result (combinational)
alu_zero  in  1  ALU zero flag
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_result  out  32  captured result
rsp_zero  out  1  captured zero flag
rsp_error  out  1  opcode was not a legal operation
acc  out  32  accumulator value
busy  out  1  FSM not in IDLE, or FIFO not empty

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty with pointers and count 0, and FSM in IDLE. All outputs 0 except cmd_ready=1 and alu_op=4'b0000 (NOOP).
- Legal opcodes: NOOP 0000, RESET 0001, OR 0010, AND 0101, ADD 0110, NOT 0111, SUB 1000, EQUAL 1100, GT 1101.
  - All other codes, including 1111, are illegal.
- FIFO:
  - cmd_ready = !full.
  - Push on cmd_valid & cmd_ready, storing {op, a, b, use_acc, wr_acc}.
  - Pop only in IDLE when not empty.
  - Push and pop in the same cycle leave the count unchanged.
  - No bypass: a command always spends at least one cycle in the FIFO.
  - When full, cmd_ready is low and no push occurs even if a pop happens that cycle.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if FIFO not empty, pop and go to EXEC. The pop loads:
    - alu_a <= use_acc ? acc : a, and alu_b <= b.
    - alu_op <= op if the op is a legal ALU op; NOOP for RESET/NOOP/illegal.
    - The op class is latched internally.
  - EXEC: one cycle for the ALU to settle, then go to RESP. Capture by class:
    - ALU ops: rsp_result <= alu_result, rsp_zero <= alu_zero, rsp_error <= 0. If wr_acc, acc <= alu_result.
    - NOOP: rsp_result <= acc, rsp_zero <= (acc==0), rsp_error <= 0.
    - RESET: acc <= 0, rsp_result <= 0, rsp_zero <= 1, rsp_error <= 0 (wr_acc ignored).
    - Illegal: rsp_result <= 0, rsp_zero <= 0, rsp_error <= 1; acc unchanged.
  - RESP: rsp_valid=1; rsp_* stay stable until rsp_ready is sampled high. Then go to IDLE with rsp_valid=0 the next cycle.
- use_acc sees the accumulator value as of the pop cycle, i.e. after every earlier command has completed. Back-to-back chaining is therefore exact.
- Latency:
  - Command accepted at edge t into an empty FIFO with FSM in IDLE: pop at t+1, capture at t+2, rsp_valid high after t+2. With rsp_ready held high it drops after t+3.
  - Throughput is one command per 3 cycles.
- Arithmetic overflow and wrap follow the ALU; this block does no width extension.
- The FIFO accepts commands while the FSM is in EXEC or RESP.
- Reset asserted mid-operation aborts immediately: the in-flight response and queued commands are lost and the accumulator is cleared.

Test Plan:
- Reset then a single ADD, a=5, b=7, rsp_ready=1 -> rsp_result=12, rsp_zero=0, rsp_error=0, rsp_valid high exactly 1 cycle, 3 cycles after acceptance; alu_op seen as 0110 during EXEC.
- Chain: ADD a=10,b=0,wr_acc; SUB use_acc,b=10,wr_acc -> second rsp_result=0, rsp_zero=1, acc=0.
- Fill: 5 commands back-to-back with rsp_ready=0 (DEPTH=4) -> cmd_ready low after the FIFO holds 4. First response is held stable for 10 cycles. Releasing rsp_ready drains all 5 in order with correct results.
- Opcode 0011 and 1111 -> rsp_error=1, rsp_result=0, acc unchanged; a following ADD 1+1 returns 2.
- RESET opcode with acc=0xDEADBEEF -> rsp_result=0, rsp_zero=1, acc=0. A NOOP afterwards returns 0 with rsp_zero=1.
- Drop rst_n during RESP with 2 commands queued -> rsp_valid, acc and busy go 0 asynchronously and cmd_ready=1. No stale response after release.
